// File: rtl/mips_defs.sv
// Shared M-stage definitions: memory opcodes, LSU state encoding and access-size decode.
package mips_defs;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
    typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_e;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        mem_size_e size;
        logic      sext;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [5:0] op);
        mem_op_t d;
        d = '0;
        case (op)
            OP_LB:   begin d.is_load  = 1'b1; d.size = BYTE; d.sext = 1'b1; end
            OP_LH:   begin d.is_load  = 1'b1; d.size = HALF; d.sext = 1'b1; end
            OP_LW:   begin d.is_load  = 1'b1; d.size = WORD; end
            OP_LBU:  begin d.is_load  = 1'b1; d.size = BYTE; end
            OP_LHU:  begin d.is_load  = 1'b1; d.size = HALF; end
            OP_SB:   begin d.is_store = 1'b1; d.size = BYTE; end
            OP_SH:   begin d.is_store = 1'b1; d.size = HALF; end
            OP_SW:   begin d.is_store = 1'b1; d.size = WORD; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_data_align.sv
// Lane steering for the data port: store byte enables/replicated data, and load lane
// select with sign or zero extension.
module mem_data_align
    import mips_defs::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_sext_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] load_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (mem_size_e'(st_size_i))
            BYTE: begin
                be_o    = 4'b0001 << st_lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            HALF: begin
                be_o    = st_lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    always_comb begin
        case (ld_lane_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        ld_half = ld_lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (mem_size_e'(ld_size_i))
            BYTE:    load_o = {{24{ld_sext_i & ld_byte[7]}}, ld_byte};
            HALF:    load_o = {{16{ld_sext_i & ld_half[15]}}, ld_half};
            default: load_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store controller: issues one data-memory access per memory instruction,
// stalls the pipeline until it completes, and reports misalignment and bus timeouts.
module mem_stage_lsu
    import mips_defs::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 0,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata_in,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       load_data,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              exc_bus,
    output logic [ADDR_W-1:0] exc_addr
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       load_q, load_d;
    logic              bus_q, bus_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] exc_addr_q;

    mem_op_t     dec;
    logic        mem_op, misal, go, timeout;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_ext;
    logic        unused_instr;

    assign unused_instr = ^instr[25:0];
    assign dec     = decode_op(instr[31:26]);
    assign mem_op  = dec.is_load | dec.is_store;
    assign misal   = ((dec.size == WORD) && (addr[1:0] != 2'b00)) ||
                     ((dec.size == HALF) && addr[0]);
    assign go      = (state_q == IDLE) && valid_in && mem_op && !misal;
    assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    assign exc_adel = (state_q == IDLE) && valid_in && dec.is_load  && misal;
    assign exc_ades = (state_q == IDLE) && valid_in && dec.is_store && misal;

    mem_data_align u_align (
        .st_size_i (dec.size),
        .st_lane_i (addr[1:0]),
        .wdata_i   (wdata_in),
        .be_o      (st_be),
        .wdata_o   (st_wdata),
        .ld_size_i (size_q),
        .ld_sext_i (sext_q),
        .ld_lane_i (lane_q),
        .rdata_i   (mem_rdata),
        .load_o    (ld_ext)
    );

    // Normal completion takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        load_d  = load_q;
        bus_d   = 1'b0;
        stall_m = 1'b0;
        mem_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    stall_m = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall_m = 1'b1;
                mem_req = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (mem_gnt && we_q) begin
                    state_d = DONE;
                end else if (mem_gnt && mem_rvalid) begin
                    load_d  = ld_ext;
                    state_d = DONE;
                end else if (timeout) begin
                    load_d  = '0;
                    bus_d   = 1'b1;
                    state_d = DONE;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall_m = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    load_d  = ld_ext;
                    state_d = DONE;
                end else if (timeout) begin
                    load_d  = '0;
                    bus_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            load_q     <= '0;
            bus_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            sext_q     <= 1'b0;
            lane_q     <= '0;
            exc_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            bus_q   <= bus_d;
            if (go) begin
                we_q    <= dec.is_store;
                addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                be_q    <= st_be;
                wdata_q <= st_wdata;
                size_q  <= dec.size;
                sext_q  <= dec.sext;
                lane_q  <= addr[1:0];
            end
            if (exc_adel || exc_ades) exc_addr_q <= addr;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign load_data = load_q;
    assign exc_bus   = bus_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a transaction-level model of access timing,
// lane steering and load extension.
module tb_mem_stage_lsu;

    localparam int TO = 8;

    localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100,
                           LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic        valid_in = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata_in = '0;
    logic        stall_m, mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] load_data;
    logic        exc_adel, exc_ades, exc_bus;
    logic [31:0] exc_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .valid_in(valid_in), .addr(addr),
        .wdata_in(wdata_in), .stall_m(stall_m), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .load_data(load_data),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus), .exc_addr(exc_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // size: 0 byte, 1 half, 2 word, -1 not a memory op
    function automatic int op_size(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 0;
            LH, LHU, SH: return 1;
            LW, SW:      return 2;
            default:     return -1;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input int sz, input logic [31:0] a);
        int lane;
        lane = int'(a[1:0]);
        if (sz == 0) return 4'(1 << lane);
        if (sz == 1) return (lane >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input int sz, input logic [31:0] wd);
        if (sz == 0) return {24'h0, wd[7:0]} * 32'h0101_0101;
        if (sz == 1) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        int sh;
        sh = (op_size(op) == 0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        v = rd >> sh;
        case (op)
            LBU: return v & 32'hFF;
            LB:  return ((v & 32'hFF) >= 32'h80) ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
            LHU: return v & 32'hFFFF;
            LH:  return ((v & 32'hFFFF) >= 32'h8000) ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
            default: return rd;
        endcase
    endfunction

    // One M-stage instruction. gnt arrives in the (gd+1)-th REQ cycle; rvalid rd cycles after it.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input int gd, input int rd, input logic [31:0] rdata);
        int sz, n, m;
        bit is_ld, is_st, mis, to;
        sz    = op_size(op);
        is_ld = (sz >= 0) && !op[3];
        is_st = (sz >= 0) && op[3];
        @(negedge clk);
        instr = {op, 26'($urandom)};
        valid_in = 1'b1; addr = a; wdata_in = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        #1;
        if (sz < 0) begin
            chk("nop_stall", 32'(stall_m), 0);
            chk("nop_req", 32'(mem_req), 0);
            return;
        end
        mis = (sz == 2 && a[1:0] != 2'b00) || (sz == 1 && a[0]);
        if (mis) begin
            chk("adel", 32'(exc_adel), 32'(is_ld));
            chk("ades", 32'(exc_ades), 32'(is_st));
            chk("mis_stall", 32'(stall_m), 0);
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            chk("exc_addr", exc_addr, a);
            chk("mis_req", 32'(mem_req), 0);
            chk("mis_adel_end", 32'(exc_adel | exc_ades), 0);
            return;
        end
        chk("idle_stall", 32'(stall_m), 1);
        chk("idle_req", 32'(mem_req), 0);
        n  = is_st ? gd + 1 : gd + 1 + rd;
        to = (n > TO);
        m  = to ? TO : n;
        for (int c = 1; c <= m; c++) begin
            @(negedge clk);
            mem_gnt    = (c == gd + 1);
            mem_rvalid = is_ld && (c == gd + 1 + rd);
            mem_rdata  = mem_rvalid ? rdata : $urandom;
            #1;
            chk("busy_stall", 32'(stall_m), 1);
            chk("busy_req", 32'(mem_req), 32'(c <= gd + 1));
            chk("busy_bus", 32'(exc_bus), 0);
            if (c <= gd + 1) begin
                chk("req_addr", mem_addr, {a[31:2], 2'b00});
                chk("req_we", 32'(mem_we), 32'(is_st));
                chk("req_be", 32'(mem_be), 32'(exp_be(sz, a)));
                if (is_st) chk("req_wdata", mem_wdata, exp_wd(sz, wd));
            end
        end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        valid_in = 1'b0;
        #1;
        chk("done_stall", 32'(stall_m), 0);
        chk("done_req", 32'(mem_req), 0);
        chk("done_bus", 32'(exc_bus), 32'(to));
        if (is_ld) chk("load_data", load_data, to ? 32'h0 : exp_ld(op, a, rdata));
    endtask

    initial begin
        logic [5:0] ops [9];
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'b001000};
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_stall", 32'(stall_m), 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_load", load_data, 0);
        chk("rst_exc", 32'({exc_adel, exc_ades, exc_bus}), 0);
        chk("rst_exc_addr", exc_addr, 0);
        reset = 1'b0;

        do_op(SB,  32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0);
        do_op(LH,  32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234);
        do_op(LHU, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234);
        do_op(LW,  32'h0000_3006, 32'h0, 0, 1, 32'h0);
        do_op(SW,  32'h0000_4000, 32'hDEAD_BEEF, 5, 0, 32'h0);
        do_op(LB,  32'h0000_5001, 32'h0, 100, 0, 32'h0);
        do_op(LW,  32'h0000_6000, 32'h0, 0, 50, 32'h0);
        do_op(SH,  32'h0000_7001, 32'h1234_5678, 0, 0, 32'h0);
        do_op(LB,  32'h0000_8003, 32'h0, 2, 0, 32'h80FF_7F01);
        do_op(6'b001000, 32'h0, 32'h0, 0, 0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int gd, rd;
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            gd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
            rd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
            do_op(ops[$urandom_range(0, 8)], a, $urandom, gd, rd, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                #1;
                chk("gap_stall", 32'(stall_m), 0);
            end
        end

        // Reset while waiting for read data; the late rvalid must be ignored.
        @(negedge clk);
        instr = {LW, 26'h0}; valid_in = 1'b1; addr = 32'h0000_9000;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk("wait_stall", 32'(stall_m), 1);
        chk("wait_req", 32'(mem_req), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; valid_in = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("postrst_stall", 32'(stall_m), 0);
        chk("postrst_req", 32'(mem_req), 0);
        chk("postrst_load", load_data, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("late_rv_load", load_data, 0);
        chk("late_rv_stall", 32'(stall_m), 0);
        chk("late_rv_exc", 32'({exc_adel, exc_ades, exc_bus}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Generalised M-stage load/store controller; successor to the single-signal M-stage write-enable decoder.
- Decodes the M-stage instruction for word, half and byte loads and stores.
- Drives a data-memory port with a valid/grant/rvalid handshake, stalls the pipeline while an access is outstanding, and returns aligned and extended load data.
- Flags misaligned addresses and bus timeouts for the exception logic.

Parameters:
- ADDR_W, 32, byte-address width of addr and mem_addr.
- TIMEOUT_CYC, 0, cycles in REQ+WAIT before bus error; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYC < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- instr  in  32  M-stage instruction
- valid_in  in  1  M-stage slot holds a live instruction
- addr  in  ADDR_W  effective address (ALU result)
- wdata_in  in  32  forwarded rt value
- stall_m  out  1  freeze the E/M register and earlier stages
- mem_req  out  1  request valid
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  word-aligned address; bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- load_data  out  32  extended load result; valid in DONE
- exc_adel  out  1  misaligned load, one-cycle pulse
- exc_ades  out  1  misaligned store, one-cycle pulse
- exc_bus  out  1  timeout, pulse in DONE
- exc_addr  out  ADDR_W  offending address, held until the next exception

Behaviour:
- Reset: state IDLE, counter 0. All outputs and registers reset to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data, stall_m, exc_adel, exc_ades, exc_bus, exc_addr.
- Decode (op = instr[31:26]):
  - Loads: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101.
  - Stores: SB 101000, SH 101001, SW 101011.
  - Any other op is a no-op for this block.
- Alignment: a word access with addr[1:0] != 0, or a half access with addr[0] != 0, is misaligned.
  - exc_adel or exc_ades pulses in the same cycle (combinational from IDLE inputs).
  - exc_addr <= addr at the next edge.
  - No request is issued, stall_m stays 0 and the state remains IDLE.
- IDLE: on valid_in & mem op & aligned:
  - stall_m = 1 combinationally.
  - At the edge, register mem_addr = {addr[ADDR_W-1:2], 2'b00}, mem_be, mem_wdata and the load kind; go to REQ.
- REQ:
  - mem_req = 1, stall_m = 1; request fields stay stable until mem_gnt.
  - gnt & store -> DONE.
  - gnt & load & rvalid (same cycle) -> capture data, DONE.
  - gnt & load without rvalid -> WAIT.
- WAIT: mem_req = 0, stall_m = 1; on mem_rvalid capture the extended rdata into load_data and go to DONE.
- DONE:
  - stall_m = 0, so the pipeline advances at this edge; load_data is valid for this cycle.
  - Next state IDLE. A new op in the following cycle starts a fresh access; the same instruction is never re-issued.
- Byte enables and store data:
  - SB: be = 0001 << addr[1:0]; wdata = {4{wdata_in[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{wdata_in[15:0]}}.
  - SW: be = 1111; wdata = wdata_in.
- Load extension:
  - Byte lane = addr[1:0], half lane = addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Timeout:
  - The counter increments each cycle in REQ or WAIT and clears on entry to IDLE.
  - If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC - 1 without completion, go to DONE with exc_bus = 1 and load_data = 0.
  - mem_req drops at that edge.
- Minimum latency:
  - Load with an immediate gnt and rvalid one cycle later: stall 3 cycles (IDLE, REQ, WAIT), then DONE.
  - Store with an immediate gnt: stall 2 cycles.
- valid_in = 0 in IDLE: no action.
- valid_in is ignored outside IDLE, because the instruction is held by stall_m.
- Reset in any state: return to IDLE at the edge; mem_req = 0 and stall_m = 0 in the next cycle. Any late rvalid arriving in IDLE is ignored.

Decomposition:
- Shared package mips_defs holds:
  - the opcode constants listed above;
  - the state enum IDLE / REQ / WAIT / DONE;
  - the size encoding BYTE / HALF / WORD plus a signed flag.
- Sub-module mem_data_align (combinational) computes be and wdata from size, addr[1:0] and wdata_in, and the extended load from rdata, size, signed flag and addr[1:0].
- The top level holds the FSM, request registers, timeout counter and exception logic.

Test Plan:
- SB, addr 0x0000_1003, wdata_in 0x0000_00AB, gnt in REQ -> mem_addr 0x1000, be 1000, wdata 0xABABABAB, stall_m high exactly 2 cycles.
- LH, addr 0x2002, gnt immediate, rvalid one cycle later with rdata 0x8001_1234 -> load_data 0xFFFF8001 in DONE, stall 3 cycles; LHU on the same data -> 0x00008001.
- LW, addr 0x3006 -> exc_adel pulse in the same cycle, exc_addr 0x3006, mem_req never asserted, stall_m 0.
- SW with gnt withheld 5 cycles -> mem_req, mem_addr, mem_be and mem_wdata stable all 5 cycles; DONE one cycle after gnt.
- TIMEOUT_CYC = 4, LB with no gnt -> exc_bus pulse in DONE after 4 REQ cycles, load_data 0, then IDLE.
- Reset asserted in WAIT, then rvalid arrives after reset -> IDLE, load_data stays 0, no stall or exception.
